// File: rtl/disp_pkg.sv
// disp_pkg: shared display constants, slot phase type and leading-zero mask helper
package disp_pkg;
  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam int MAX_DIGITS = 8;
  typedef enum logic {PH_DEAD, PH_ON} phase_t;
  // Bit k set when digit k and every more-significant digit are zero; digit 0 never blanks
  function automatic logic [MAX_DIGITS-1:0] lz_mask(input logic [4*MAX_DIGITS-1:0] disp, input int digits);
    logic z;
    z = 1'b1;
    lz_mask = '0;
    for (int k = MAX_DIGITS - 1; k > 0; k--)
      if (k < digits) begin
        z = z && (disp[4*k +: 4] == 4'd0);
        lz_mask[k] = z;
      end
  endfunction
endpackage

// File: rtl/scan_prescaler.sv
// scan_prescaler: per-slot cycle counter and wrapping digit slot index
module scan_prescaler #(
  parameter int DIV = 50000,
  parameter int DIGITS = 4,
  localparam int CW = $clog2(DIV),
  localparam int IW = $clog2(DIGITS)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [CW-1:0] cnt,
  output logic          slot_end,
  output logic [IW-1:0] idx
);
  assign slot_end = cnt == CW'(DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) idx <= idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
    end
endmodule

// File: rtl/bcd_scan_driver.sv
// bcd_scan_driver: multiplexed BCD scan with frame-aligned display updates and leading-zero blanking
module bcd_scan_driver
  import disp_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DIV = 50000,
  parameter int BLANK = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  blank_lz,
  output logic [3:0]            bcd,
  output logic [DIGITS-1:0]     an,
  output logic                  pending,
  output logic                  frame_tick
);
  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(DIGITS);
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic slot_end, frame_end;
  logic [4*DIGITS-1:0] shadow, disp;
  logic [MAX_DIGITS-1:0] lz;
  logic [3:0] d, d_out;
  phase_t phase;
  scan_prescaler #(.DIV(DIV), .DIGITS(DIGITS)) u_pre (
    .clk(clk),
    .rst_n(rst_n),
    .cnt(cnt),
    .slot_end(slot_end),
    .idx(idx)
  );
  assign frame_end = slot_end && idx == IW'(DIGITS - 1);
  always_comb begin
    lz = lz_mask((4*MAX_DIGITS)'(disp), DIGITS);
    d = disp[4*idx +: 4];
    phase = cnt < CW'(BLANK) ? PH_DEAD : PH_ON;
    d_out = (phase == PH_DEAD || d > BCD_MAX || (blank_lz && lz[idx])) ? BCD_BLANK : d;
  end
  // A load in the boundary cycle wins over the transfer, so it waits a full frame
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      shadow <= '0;
      disp <= '0;
      pending <= 1'b0;
      frame_tick <= 1'b0;
      an <= '1;
      bcd <= BCD_BLANK;
    end else begin
      frame_tick <= frame_end;
      bcd <= d_out;
      an <= phase == PH_DEAD ? '1 : ~(DIGITS'(1) << idx);
      if (load) begin
        shadow <= value;
        pending <= 1'b1;
      end else if (frame_end && pending) begin
        disp <= shadow;
        pending <= 1'b0;
      end
    end
endmodule
